// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI target endpoint.
package spi_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  // Idle level of sclk for a given SPI mode.
  function automatic logic cpol(input int mode);
    return ((mode >> 1) & 1) != 0;
  endfunction

  // Clock phase: 1 means data is launched on the first edge of each bit.
  function automatic logic cpha(input int mode);
    return (mode & 1) != 0;
  endfunction

  // Index of the bit that goes on the wire first (and is filled last on rx).
  function automatic int first_bit(input int width, input int msb_first);
    return (msb_first != 0) ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// N-stage flop synchroniser with a configurable reset level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous pin through the chain.
  always_ff @(posedge clk) begin
    if (rst) ff <= {STAGES{RST_VAL}};
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_slave_rx_tx.sv
// SPI target: oversamples sclk/mosi/ss, deserialises mosi, serialises a host word on miso.
module spi_slave_rx_tx
  import spi_pkg::*;
#(
  parameter int MODE             = 0,
  parameter int DATA_WIDTH       = 16,
  parameter int SLAVE_ACTIVE_LOW = 1,
  parameter int MSB_FIRST        = 1,
  parameter int SYNC_STAGES      = 2,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX_VALUE = DATA_WIDTH'(16'hA5A5)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  tx_underrun,
  output logic                  frame_err
);

  localparam logic CPOL   = cpol(MODE);
  localparam logic CPHA   = cpha(MODE);
  localparam int   FB     = first_bit(DATA_WIDTH, MSB_FIRST);
  localparam int   CW     = $clog2(DATA_WIDTH);
  localparam logic SS_OFF = (SLAVE_ACTIVE_LOW != 0);

  logic sclk_s, mosi_s, ss_s, sclk_prev, ss_act, ss_act_prev;
  logic rise, fall, sample_edge, shift_edge, start, reload;
  state_t state;
  logic [DATA_WIDTH-1:0] tx_sr, rx_sr, hold, load_word, tx_next, rx_next;
  logic hold_full, word_end, first_pend, rx_done;
  logic [CW-1:0] rx_cnt;

  // Pins reset to their idle levels so leaving reset creates no edges.
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL))   u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0))   u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SS_OFF)) u_sync_ss   (.clk(clk), .rst(rst), .d(ss),   .q(ss_s));

  assign ss_act      = ss_s ^ SS_OFF;
  assign rise        = sclk_s & ~sclk_prev;
  assign fall        = ~sclk_s & sclk_prev;
  // Modes 0/3 sample on rising sclk, modes 1/2 on falling.
  assign sample_edge = (CPOL ^ CPHA) ? fall : rise;
  assign shift_edge  = (CPOL ^ CPHA) ? rise : fall;

  assign start  = (state == IDLE) && ss_act && !ss_act_prev;
  assign reload = (state == SHIFT) && ss_act && shift_edge && word_end;

  assign load_word = hold_full ? hold : DEFAULT_TX_VALUE;
  assign tx_next   = (MSB_FIRST != 0) ? {tx_sr[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_sr[DATA_WIDTH-1:1]};
  assign rx_next   = (MSB_FIRST != 0) ? {rx_sr[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_sr[DATA_WIDTH-1:1]};
  assign tx_ready  = ~hold_full;

  // Previous synced sclk and ss for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev   <= CPOL;
      ss_act_prev <= 1'b0;
    end else begin
      sclk_prev   <= sclk_s;
      ss_act_prev <= ss_act;
    end
  end

  // Holding register: host writes when empty; every TX load drains it or underruns.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold        <= '0;
      hold_full   <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= 1'b0;
      if (start || reload) begin
        if (hold_full) hold_full   <= 1'b0;
        else           tx_underrun <= 1'b1;
      end
      // Only possible while empty, so it never collides with the drain above.
      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  // Frame FSM: tx serialiser, rx deserialiser and the ss-drop handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      miso       <= 1'b0;
      busy       <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      rx_cnt     <= '0;
      word_end   <= 1'b0;
      first_pend <= 1'b0;
      rx_done    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
      // Publish a completed word one cycle after its last sample.
      if (rx_done) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
      end
      case (state)
        IDLE: begin
          busy <= 1'b0;
          miso <= 1'b0;
          if (start) begin
            state      <= SHIFT;
            busy       <= 1'b1;
            rx_cnt     <= '0;
            word_end   <= 1'b0;
            tx_sr      <= load_word;
            miso       <= CPHA ? 1'b0 : load_word[FB];
            first_pend <= CPHA;
          end
        end
        SHIFT: begin
          if (!ss_act) begin
            // ss wins over a coincident sample; partial rx and tx words are dropped.
            state      <= IDLE;
            busy       <= 1'b0;
            miso       <= 1'b0;
            word_end   <= 1'b0;
            first_pend <= 1'b0;
            rx_cnt     <= '0;
            if (rx_cnt != '0) frame_err <= 1'b1;
          end else if (sample_edge) begin
            rx_sr <= rx_next;
            if (rx_cnt == CW'(DATA_WIDTH - 1)) begin
              rx_cnt   <= '0;
              rx_done  <= 1'b1;
              word_end <= 1'b1;
            end else begin
              rx_cnt <= rx_cnt + 1'b1;
            end
          end else if (shift_edge) begin
            if (word_end) begin
              // Back-to-back word: reload and present its first bit with no gap.
              tx_sr      <= load_word;
              miso       <= load_word[FB];
              word_end   <= 1'b0;
              first_pend <= 1'b0;
            end else if (first_pend) begin
              miso       <= tx_sr[FB];
              first_pend <= 1'b0;
            end else begin
              tx_sr <= tx_next;
              miso  <= tx_next[FB];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
